mom_cap_trim_ctrl: RTL

MOM_CAP_TRIM_CTRL -- requirements
Module: mom_cap_trim_ctrl

---
 rtl/mom_cap_trim_ctrl.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/mom_cap_trim_ctrl.sv
// -----------------------------------------------------------------------------
// mom_cap_trim_ctrl
//
// Successive-approximation trim controller for a binary-weighted MOM capacitor
// bank. A run tries each bit from MSB to LSB. For each bit it presents the
// trial code, waits SETTLE_CYC cycles for the analog path to settle, and then
// samples the comparator. CMP=1 means the bank is too large, so the trial bit
// is cleared. The final code is the largest code that does not exceed the
// target. The code saturates to all-zeros or all-ones at the ends of the range.
//
// A manual override (FORCE_EN) has priority over any run. It aborts the run
// without a DONE pulse and loads FORCE_CODE into CODE, with 1-cycle latency.
//
// Parameters
//   WIDTH      : number of trim bits (2..10)
//   SETTLE_CYC : analog settle cycles per trial (1..255)
//
// Ports
//   CLK        : clock; all state changes on the rising edge
//   RST        : synchronous active-high reset
//   START      : request a trim run (sampled only in IDLE)
//   CMP        : comparator, 1 = bank capacitance exceeds target
//   FORCE_EN   : manual override enable (aborts a run, wins over START)
//   FORCE_CODE : manual trim code
//   CODE       : registered trim code to the capacitor segment enables
//   BUSY       : high while a run is in progress (SET/SETTLE/SAMPLE/FINISH)
//   DONE       : one-cycle pulse in FINISH
//   DBG_STATE  : current FSM state (IDLE=0 SET=1 SETTLE=2 SAMPLE=3 FINISH=4)
//
// Handshake: START is a level that is sampled only while the FSM is in IDLE.
// There is no ready/ack signal. BUSY=1 means a START is dropped, not queued.
// DONE marks the single cycle in which CODE carries the new result.
// -----------------------------------------------------------------------------
module mom_cap_trim_ctrl #(
  parameter int WIDTH      = 6,
  parameter int SETTLE_CYC = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic             CMP,
  input  logic             FORCE_EN,
  input  logic [WIDTH-1:0] FORCE_CODE,
  output logic [WIDTH-1:0] CODE,
  output logic             BUSY,
  output logic             DONE,
  output logic [2:0]       DBG_STATE
);

  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  // Mid-scale reset code: MSB set, all other bits clear.
  localparam logic [WIDTH-1:0] MID_CODE  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ONE_CODE  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [IDX_W-1:0] TOP_IDX   = IDX_W'(WIDTH - 1);
  localparam logic [7:0]       SETTLE_LD = 8'(SETTLE_CYC);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SET    = 3'd1,
    SETTLE = 3'd2,
    SAMPLE = 3'd3,
    FINISH = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] code_q, code_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;

  // One-hot mask of the bit currently under trial.
  logic [WIDTH-1:0] trial_mask;

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      code_q  <= MID_CODE;
      cnt_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and datapath logic
  //
  // code_q is the result register and the trial register at the same time.
  // Bits above the index hold decided values. The bit at the index is the
  // trial bit. Bits below the index are zero. So in SET, CODE already equals
  // the result with the current bit set, and no separate result copy is
  // needed.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    code_d     = code_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    trial_mask = ONE_CODE << idx_q;

    unique case (state_q)
      IDLE: begin
        if (START) begin
          state_d = SET;
          idx_d   = TOP_IDX;
          // Cleared result with the MSB trial bit already applied.
          code_d  = MID_CODE;
        end
      end

      SET: begin
        state_d = SETTLE;
        cnt_d   = SETTLE_LD;
      end

      SETTLE: begin
        cnt_d = cnt_q - 8'd1;
        // The counter enters at SETTLE_CYC and leaves at 1, which gives
        // exactly SETTLE_CYC cycles in this state.
        if (cnt_q <= 8'd1) begin
          state_d = SAMPLE;
          cnt_d   = '0;
        end
      end

      SAMPLE: begin
        if (CMP) begin
          code_d = code_q & ~trial_mask;
        end
        if (idx_q != '0) begin
          idx_d   = idx_q - 1'b1;
          // The next lower bit becomes the new trial bit.
          code_d  = code_d | (trial_mask >> 1);
          state_d = SET;
        end else begin
          state_d = FINISH;
        end
      end

      FINISH: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // The override beats both START and any run in progress. Because DONE is
    // decoded from FINISH, moving straight to IDLE also suppresses the pulse.
    if (FORCE_EN) begin
      state_d = IDLE;
      code_d  = FORCE_CODE;
      cnt_d   = '0;
      idx_d   = '0;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs (all decoded from registered state)
  // ---------------------------------------------------------------------------
  assign CODE      = code_q;
  assign BUSY      = (state_q != IDLE);
  assign DONE      = (state_q == FINISH);
  assign DBG_STATE = state_q;

endmodule
